// File: rtl/instr_mem_loader_if.sv
// Instruction-load bus: source-side fields/handshake plus the imem write port and session status.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              start;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [18:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              done;
  logic              err;

  modport master (
    output start, finish, in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, full, done, err
  );

  modport slave (
    input  start, finish, in_valid, in_op, in_rd, in_rn, in_rm, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata, count, full, done, err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// LEGv8 instruction encoder/loader: packs mnemonic + fields into R/D/CB machine words and
// writes them to consecutive imem word addresses, one instruction every two cycles.
module instr_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_loader_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;
  logic              fin_pend_reg;
  logic              full_w;
  logic              accept;
  logic              legal;

  function automatic logic [31:0] encode(input logic [2:0] op, input logic [4:0] rd,
                                         input logic [4:0] rn, input logic [4:0] rm,
                                         input logic [18:0] imm);
    logic [31:0] w;
    case (op)
      3'd0:    w = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
      3'd1:    w = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
      3'd2:    w = {11'b10001011000, rm, 6'b000000, rn, rd};
      3'd3:    w = {11'b11001011000, rm, 6'b000000, rn, rd};
      3'd4:    w = {11'b10001010000, rm, 6'b000000, rn, rd};
      3'd5:    w = {11'b10101010000, rm, 6'b000000, rn, rd};
      3'd6:    w = {8'b10110100, imm, rd};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  assign full_w = (count_reg == CNT_W'(DEPTH));
  assign accept = (state_reg == LOAD) && !full_w && bus.in_valid;
  assign legal  = (bus.in_op != 3'd7);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (bus.start) state_next = LOAD;
      LOAD: begin
        if (accept && legal)  state_next = WRITE;
        else if (bus.finish)  state_next = DONE;
      end
      WRITE: state_next = fin_pend_reg ? DONE : LOAD;
      DONE:  if (bus.start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Address/data are latched at accept so they stay stable through the strobe and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      err_reg      <= 1'b0;
      fin_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            count_reg    <= '0;
            err_reg      <= 1'b0;
            fin_pend_reg <= 1'b0;
          end
        end
        LOAD: begin
          if (accept && legal) begin
            addr_reg     <= ADDR_W'({count_reg, 2'b00});
            wdata_reg    <= encode(bus.in_op, bus.in_rd, bus.in_rn, bus.in_rm, bus.in_imm);
            fin_pend_reg <= bus.finish;
          end else if (accept) begin
            err_reg <= 1'b1;
          end
        end
        WRITE: begin
          count_reg    <= count_reg + 1'b1;
          fin_pend_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Strobe is masked by reset so a write interrupted by reset never reaches memory.
  always_comb begin
    bus.in_ready = (state_reg == LOAD) && !full_w;
    bus.imem_we  = (state_reg == WRITE) && !rst;
    bus.done     = (state_reg == DONE);
  end

  assign bus.imem_addr  = addr_reg;
  assign bus.imem_wdata = wdata_reg;
  assign bus.count      = count_reg;
  assign bus.full       = full_w;
  assign bus.err        = err_reg;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with DEPTH=4: encoding, addressing, illegal op, full, finish, reset.
module tb_instr_mem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  instr_mem_loader_if #(.ADDR_W(8), .DEPTH(4)) bus ();

  instr_mem_loader #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [18:0] imm, input logic fin);
    bus.in_op = op; bus.in_rd = rd; bus.in_rn = rn; bus.in_rm = rm; bus.in_imm = imm;
    bus.in_valid = 1'b1; bus.finish = fin;
    tick();
    bus.in_valid = 1'b0; bus.finish = 1'b0;
    $display("txn op=%0d rd=%0d rn=%0d rm=%0d imm=%h fin=%0d -> we=%0d addr=%h wdata=%h",
             op, rd, rn, rm, imm, fin, bus.imem_we, bus.imem_addr, bus.imem_wdata);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b exp 0", bus.in_ready); end
    n_cmp++; if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b exp 0", bus.imem_we); end
    n_cmp++; if ({bus.full, bus.done, bus.err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {bus.full, bus.done, bus.err}); end
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_cmp++; if ({bus.imem_addr, bus.imem_wdata} !== 40'd0) begin n_bad++; $display("FAIL reset_bus got %h/%h exp 0/0", bus.imem_addr, bus.imem_wdata); end
  endtask

  task automatic test_add();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready got %b exp 1", bus.in_ready); end
    drive(3'd2, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0);
    n_cmp++; if (bus.imem_we !== 1'b1) begin n_bad++; $display("FAIL add_we got %b exp 1", bus.imem_we); end
    n_cmp++; if (bus.imem_addr !== 8'h00) begin n_bad++; $display("FAIL add_addr got %h exp 00", bus.imem_addr); end
    n_cmp++; if (bus.imem_wdata !== 32'h8B030041) begin n_bad++; $display("FAIL add_wdata got %h exp 8B030041", bus.imem_wdata); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL add_ready_write got %b exp 0", bus.in_ready); end
    tick();
    n_cmp++; if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL add_we_after got %b exp 0", bus.imem_we); end
    n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL add_count got %0d exp 1", bus.count); end
    n_cmp++; if (bus.imem_wdata !== 32'h8B030041) begin n_bad++; $display("FAIL add_wdata_hold got %h exp 8B030041", bus.imem_wdata); end
  endtask

  task automatic test_ldur_cbz();
    drive(3'd0, 5'd5, 5'd6, 5'd0, 19'd8, 1'b0);
    n_cmp++; if (bus.imem_we !== 1'b1) begin n_bad++; $display("FAIL ldur_we got %b exp 1", bus.imem_we); end
    n_cmp++; if (bus.imem_addr !== 8'h04) begin n_bad++; $display("FAIL ldur_addr got %h exp 04", bus.imem_addr); end
    n_cmp++; if (bus.imem_wdata !== 32'hF84080C5) begin n_bad++; $display("FAIL ldur_wdata got %h exp F84080C5", bus.imem_wdata); end
    tick();
    drive(3'd6, 5'd9, 5'd3, 5'd4, 19'h7FFFF, 1'b0);
    n_cmp++; if (bus.imem_addr !== 8'h08) begin n_bad++; $display("FAIL cbz_addr got %h exp 08", bus.imem_addr); end
    n_cmp++; if (bus.imem_wdata !== 32'hB4FFFFE9) begin n_bad++; $display("FAIL cbz_wdata got %h exp B4FFFFE9", bus.imem_wdata); end
    tick();
    n_cmp++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL cbz_count got %0d exp 3", bus.count); end
  endtask

  task automatic test_illegal();
    drive(3'd7, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0);
    n_cmp++; if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL ill_we got %b exp 0", bus.imem_we); end
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL ill_err got %b exp 1", bus.err); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready got %b exp 1", bus.in_ready); end
    n_cmp++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL ill_count got %0d exp 3", bus.count); end
    drive(3'd5, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0);
    n_cmp++; if (bus.imem_we !== 1'b1) begin n_bad++; $display("FAIL orr_we got %b exp 1", bus.imem_we); end
    n_cmp++; if (bus.imem_addr !== 8'h0C) begin n_bad++; $display("FAIL orr_addr got %h exp 0C", bus.imem_addr); end
    n_cmp++; if (bus.imem_wdata !== 32'hAA030041) begin n_bad++; $display("FAIL orr_wdata got %h exp AA030041", bus.imem_wdata); end
    tick();
  endtask

  task automatic test_full();
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d exp 4", bus.count); end
    n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL full_flag got %b exp 1", bus.full); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b exp 0", bus.in_ready); end
    bus.in_op = 3'd4; bus.in_rd = 5'd1; bus.in_rn = 5'd2; bus.in_rm = 5'd3; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("txn held-off 5th instr cycle %0d -> we=%0d count=%0d", i, bus.imem_we, bus.count);
      n_cmp++; if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL full_holdoff_we got %b exp 0", bus.imem_we); end
      n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_holdoff_count got %0d exp 4", bus.count); end
    end
    bus.in_valid = 1'b0;
    bus.finish = 1'b1; tick(); bus.finish = 1'b0;
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL full_done got %b exp 1", bus.done); end
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL full_done_count got %0d exp 4", bus.count); end
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL full_err_sticky got %b exp 1", bus.err); end
  endtask

  task automatic test_finish_with_accept();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n_cmp++; if ({bus.count, bus.done, bus.err} !== 5'b000_0_0) begin n_bad++; $display("FAIL restart_clear got %b exp 00000", {bus.count, bus.done, bus.err}); end
    drive(3'd3, 5'd1, 5'd2, 5'd3, 19'd0, 1'b1);
    n_cmp++; if (bus.imem_we !== 1'b1) begin n_bad++; $display("FAIL sub_we got %b exp 1", bus.imem_we); end
    n_cmp++; if (bus.imem_addr !== 8'h00) begin n_bad++; $display("FAIL sub_addr got %h exp 00", bus.imem_addr); end
    n_cmp++; if (bus.imem_wdata !== 32'hCB030041) begin n_bad++; $display("FAIL sub_wdata got %h exp CB030041", bus.imem_wdata); end
    tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL sub_done got %b exp 1", bus.done); end
    n_cmp++; if (bus.count !== 3'd1) begin n_bad++; $display("FAIL sub_count got %0d exp 1", bus.count); end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL restart_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL restart_ready got %b exp 1", bus.in_ready); end
    drive(3'd1, 5'd5, 5'd6, 5'd0, 19'd8, 1'b0);
    n_cmp++; if (bus.imem_addr !== 8'h00) begin n_bad++; $display("FAIL stur_addr got %h exp 00", bus.imem_addr); end
    n_cmp++; if (bus.imem_wdata !== 32'hF80080C5) begin n_bad++; $display("FAIL stur_wdata got %h exp F80080C5", bus.imem_wdata); end
    tick();
  endtask

  task automatic test_reset_during_write();
    drive(3'd4, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0);
    n_cmp++; if (bus.imem_wdata !== 32'h8A030041) begin n_bad++; $display("FAIL and_wdata got %h exp 8A030041", bus.imem_wdata); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (bus.imem_we !== 1'b0) begin n_bad++; $display("FAIL rstw_we got %b exp 0", bus.imem_we); end
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL rstw_count got %0d exp 0", bus.count); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rstw_ready got %b exp 0", bus.in_ready); end
    n_cmp++; if ({bus.imem_addr, bus.imem_wdata} !== 40'd0) begin n_bad++; $display("FAIL rstw_bus got %h/%h exp 0/0", bus.imem_addr, bus.imem_wdata); end
    tick();
    n_cmp++; if ({bus.imem_we, bus.in_ready, bus.done} !== 3'b000) begin n_bad++; $display("FAIL rstw_idle got %b exp 000", {bus.imem_we, bus.in_ready, bus.done}); end
  endtask

  initial begin
    bus.start = 1'b0; bus.finish = 1'b0; bus.in_valid = 1'b0;
    bus.in_op = 3'd0; bus.in_rd = 5'd0; bus.in_rn = 5'd0; bus.in_rm = 5'd0; bus.in_imm = 19'd0;
    test_reset();
    test_add();
    test_ldur_cbz();
    test_illegal();
    test_full();
    test_finish_with_accept();
    test_reset_during_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
